// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-memory loads/stores over a req/gnt/rvalid bus,
// resolves taken branches and registers the writeback entry for the WB stage.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int RD_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     result,
  input  logic [31:0]     store_data,
  input  logic            write,
  input  logic            wb_sel,
  input  logic            branch,
  input  logic            branch_dec,
  input  logic [RD_W-1:0] rd_in,
  input  logic            reg_we_in,
  output logic            stall,
  output logic            flush,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            wb_valid,
  output logic [31:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_we,
  output logic            bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;

  logic        mem_op;
  logic        misaligned;
  logic        aligned_op;
  logic        timeout_hit;
  logic        req_c;
  logic        stall_c;
  logic        alu_done;
  logic        mis_done;
  logic        store_done;
  logic        load_done;
  logic        abort;
  logic        wb_valid_n;
  logic        wb_we_n;
  logic [31:0] wb_data_n;

  assign mem_op      = in_valid & (write | wb_sel);
  assign misaligned  = mem_op & (result[1:0] != 2'b00);
  assign aligned_op  = mem_op & ~misaligned;
  assign timeout_hit = (state != IDLE) && (cnt == LIMIT);

  assign mem_addr  = result;
  assign mem_wdata = store_data;
  assign mem_we    = write;

  always_comb begin
    state_n    = state;
    req_c      = 1'b0;
    store_done = 1'b0;
    load_done  = 1'b0;
    abort      = 1'b0;
    alu_done   = 1'b0;
    mis_done   = 1'b0;
    case (state)
      IDLE: begin
        alu_done = in_valid & ~mem_op;
        mis_done = misaligned;
        if (aligned_op) begin
          req_c = 1'b1;
          if (mem_gnt) begin
            if (write) store_done = 1'b1;
            else       state_n    = WAIT;
          end else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (timeout_hit) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else begin
          req_c = 1'b1;
          if (mem_gnt) begin
            if (write) begin
              store_done = 1'b1;
              state_n    = IDLE;
            end else begin
              state_n = WAIT;
            end
          end
        end
      end
      WAIT: begin
        // Data arriving on the final allowed cycle still wins over the abort.
        if (mem_rvalid) begin
          load_done = 1'b1;
          state_n   = IDLE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    stall_c = (state_n != IDLE);
  end

  // Bus-facing and hazard outputs are forced low while reset is held.
  assign mem_req = rst_n & req_c;
  assign stall   = rst_n & stall_c;
  assign flush   = rst_n & in_valid & branch & branch_dec & ~stall_c;

  always_comb begin
    wb_valid_n = alu_done | mis_done | store_done | load_done | abort;
    wb_we_n    = 1'b0;
    wb_data_n  = wb_data;
    if (alu_done) begin
      wb_we_n   = reg_we_in;
      wb_data_n = result;
    end else if (load_done) begin
      wb_we_n   = reg_we_in;
      wb_data_n = mem_rdata;
    end else if (store_done) begin
      wb_data_n = result;
    end else if (mis_done | abort) begin
      wb_data_n = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      wb_valid <= 1'b0;
      wb_data  <= 32'h0;
      wb_rd    <= '0;
      wb_we    <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= ((state == IDLE) || (state_n == IDLE)) ? '0 : cnt + 1'b1;
      wb_valid <= wb_valid_n;
      wb_data  <= wb_data_n;
      wb_rd    <= rd_in;
      wb_we    <= wb_we_n;
      bus_err  <= bus_err | mis_done | abort;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized instruction
// streams checked against a cycle-count model of the memory access protocol.
module tb_mem_stage;

  localparam int TIMEOUT = 16;
  localparam int RD_W    = 5;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [31:0]     result;
  logic [31:0]     store_data;
  logic            write;
  logic            wb_sel;
  logic            branch;
  logic            branch_dec;
  logic [RD_W-1:0] rd_in;
  logic            reg_we_in;
  logic            stall;
  logic            flush;
  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;
  logic            wb_valid;
  logic [31:0]     wb_data;
  logic [RD_W-1:0] wb_rd;
  logic            wb_we;
  logic            bus_err;

  int   tests_run    = 0;
  int   tests_failed = 0;
  logic err_exp      = 1'b0;

  mem_stage #(.TIMEOUT(TIMEOUT), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .result(result),
    .store_data(store_data), .write(write), .wb_sel(wb_sel), .branch(branch),
    .branch_dec(branch_dec), .rd_in(rd_in), .reg_we_in(reg_we_in),
    .stall(stall), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    in_valid   = 1'b0;
    result     = 32'h0;
    store_data = 32'h0;
    write      = 1'b0;
    wb_sel     = 1'b0;
    branch     = 1'b0;
    branch_dec = 1'b0;
    rd_in      = '0;
    reg_we_in  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  // kind: 0 ALU, 1 branch, 2 store, 3 load. gnt comes g cycles after issue, rvalid l cycles after gnt.
  task automatic issue_op(input int kind, input logic [31:0] res, input logic [31:0] sdata,
                          input logic [31:0] rdata, input logic [RD_W-1:0] rd, input logic we,
                          input logic bdec, input int g, input int l,
                          output int stall_cyc, output int req_cyc, output logic flush0,
                          output logic [31:0] addr0, output logic [31:0] wdata0,
                          output logic mwe0, output int wbv_during, output logic bound_hit);
    int  k;
    bit  done;
    @(negedge clk);
    in_valid   = 1'b1;
    result     = res;
    store_data = sdata;
    rd_in      = rd;
    reg_we_in  = we;
    write      = (kind == 2);
    wb_sel     = (kind == 3);
    branch     = (kind == 1);
    branch_dec = bdec;
    mem_rdata  = rdata;
    mem_gnt    = (g == 0);
    mem_rvalid = 1'b0;
    #1;
    flush0     = flush;
    addr0      = mem_addr;
    wdata0     = mem_wdata;
    mwe0       = mem_we;
    stall_cyc  = 0;
    req_cyc    = 0;
    wbv_during = 0;
    bound_hit  = 1'b0;
    k          = 0;
    done       = 1'b0;
    while (!done) begin
      if (mem_req) req_cyc++;
      if (!stall) begin
        done = 1'b1;
      end else begin
        stall_cyc++;
        k++;
        if (k > TIMEOUT + 8) begin
          bound_hit = 1'b1;
          done      = 1'b1;
        end else begin
          @(negedge clk);
          mem_gnt    = (k == g);
          mem_rvalid = (k == g + l);
          #1;
          if (wb_valid) wbv_during++;
        end
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    #12;
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wb_valid: got %b expected 0", wb_valid); end
    tests_run++; if (wb_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_wb_data: got %h expected 0", wb_data); end
    tests_run++; if (wb_we !== 1'b0 || wb_rd !== '0) begin tests_failed++; $display("[TB] FAIL reset_wb_we_rd: got %b/%0d expected 0/0", wb_we, wb_rd); end
    tests_run++; if (bus_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_bus_err: got %b expected 0", bus_err); end
    tests_run++; if ({stall, mem_req, flush} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_comb: got %b expected 000", {stall, mem_req, flush}); end
    @(negedge clk);
    rst_n = 1'b1;
    err_exp = 1'b0;
  endtask

  task automatic test_alu();
    int sc, rc, wd; logic f0, mw, bh; logic [31:0] a0, w0;
    issue_op(0, 32'h1234, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 0, 1, sc, rc, f0, a0, w0, mw, wd, bh);
    tests_run++; if (sc !== 0 || rc !== 0) begin tests_failed++; $display("[TB] FAIL alu_no_stall: got stall %0d req %0d expected 0/0", sc, rc); end
    tests_run++; if (wb_valid !== 1'b1 || wb_data !== 32'h1234) begin tests_failed++; $display("[TB] FAIL alu_wb: got %b/%h expected 1/00001234", wb_valid, wb_data); end
    tests_run++; if (wb_rd !== 5'd3 || wb_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL alu_rd_we: got %0d/%b expected 3/1", wb_rd, wb_we); end
    @(negedge clk); #1;
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL alu_single_pulse: got %b expected 0", wb_valid); end
  endtask

  task automatic test_store();
    int sc, rc, wd; logic f0, mw, bh; logic [31:0] a0, w0;
    issue_op(2, 32'h100, 32'hDEADBEEF, 32'h0, 5'd7, 1'b0, 1'b0, 0, 1, sc, rc, f0, a0, w0, mw, wd, bh);
    tests_run++; if (rc !== 1 || sc !== 0) begin tests_failed++; $display("[TB] FAIL store_req_stall: got req %0d stall %0d expected 1/0", rc, sc); end
    tests_run++; if (mw !== 1'b1 || a0 !== 32'h100 || w0 !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL store_bus: got we %b addr %h data %h expected 1/00000100/deadbeef", mw, a0, w0); end
    tests_run++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL store_wb: got %b/%b expected 1/0", wb_valid, wb_we); end
  endtask

  task automatic test_load_waits();
    int sc, rc, wd; logic f0, mw, bh; logic [31:0] a0, w0;
    issue_op(3, 32'h200, 32'h0, 32'hCAFEF00D, 5'd9, 1'b1, 1'b0, 2, 3, sc, rc, f0, a0, w0, mw, wd, bh);
    tests_run++; if (sc !== 5) begin tests_failed++; $display("[TB] FAIL load_stall_cycles: got %0d expected 5", sc); end
    tests_run++; if (rc !== 3) begin tests_failed++; $display("[TB] FAIL load_req_cycles: got %0d expected 3", rc); end
    tests_run++; if (wd !== 0) begin tests_failed++; $display("[TB] FAIL load_wb_during_stall: got %0d expected 0", wd); end
    tests_run++; if (wb_valid !== 1'b1 || wb_data !== 32'hCAFEF00D || wb_we !== 1'b1 || wb_rd !== 5'd9) begin tests_failed++; $display("[TB] FAIL load_wb: got %b/%h/%b/%0d expected 1/cafef00d/1/9", wb_valid, wb_data, wb_we, wb_rd); end
  endtask

  task automatic test_branch_flush();
    int sc, rc, wd; logic f0, mw, bh; logic [31:0] a0, w0;
    issue_op(1, 32'h4444, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1, 0, 1, sc, rc, f0, a0, w0, mw, wd, bh);
    tests_run++; if (f0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL branch_taken_flush: got %b expected 1", f0); end
    tests_run++; if (wb_valid !== 1'b1 || wb_data !== 32'h4444 || wb_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL branch_wb: got %b/%h/%b expected 1/00004444/1", wb_valid, wb_data, wb_we); end
    issue_op(1, 32'h5555, 32'h0, 32'h0, 5'd5, 1'b0, 1'b0, 0, 1, sc, rc, f0, a0, w0, mw, wd, bh);
    tests_run++; if (f0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL branch_not_taken_flush: got %b expected 0", f0); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; result = 32'hA0; rd_in = 5'd1; reg_we_in = 1'b1;
    @(negedge clk);
    drive_idle();
    in_valid = 1'b1; write = 1'b1; result = 32'h300; store_data = 32'h77; mem_gnt = 1'b1;
    #1;
    tests_run++; if (wb_valid !== 1'b1 || wb_data !== 32'hA0 || wb_rd !== 5'd1) begin tests_failed++; $display("[TB] FAIL b2b_first_wb: got %b/%h/%0d expected 1/000000a0/1", wb_valid, wb_data, wb_rd); end
    tests_run++; if (mem_req !== 1'b1 || stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_store_issue: got req %b stall %b expected 1/0", mem_req, stall); end
    @(negedge clk);
    drive_idle();
    in_valid = 1'b1; result = 32'hB0; rd_in = 5'd2; reg_we_in = 1'b1;
    #1;
    tests_run++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_store_wb: got %b/%b expected 1/0", wb_valid, wb_we); end
    @(negedge clk);
    drive_idle();
    #1;
    tests_run++; if (wb_valid !== 1'b1 || wb_data !== 32'hB0 || wb_rd !== 5'd2 || wb_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_third_wb: got %b/%h/%0d/%b expected 1/000000b0/2/1", wb_valid, wb_data, wb_rd, wb_we); end
    @(negedge clk); #1;
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle: got %b expected 0", wb_valid); end
  endtask

  task automatic test_misaligned();
    int sc, rc, wd; logic f0, mw, bh; logic [31:0] a0, w0;
    issue_op(3, 32'h102, 32'h0, 32'h11, 5'd4, 1'b1, 1'b0, 0, 1, sc, rc, f0, a0, w0, mw, wd, bh);
    err_exp = 1'b1;
    tests_run++; if (rc !== 0 || sc !== 0) begin tests_failed++; $display("[TB] FAIL misaligned_no_req: got req %0d stall %0d expected 0/0", rc, sc); end
    tests_run++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL misaligned_wb: got %b/%b/%h expected 1/0/0", wb_valid, wb_we, wb_data); end
    tests_run++; if (bus_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL misaligned_err: got %b expected 1", bus_err); end
    issue_op(0, 32'h9, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 0, 1, sc, rc, f0, a0, w0, mw, wd, bh);
    tests_run++; if (bus_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_sticky: got %b expected 1", bus_err); end
  endtask

  task automatic test_timeout();
    int sc, rc, wd; logic f0, mw, bh; logic [31:0] a0, w0;
    issue_op(3, 32'h400, 32'h0, 32'h55, 5'd6, 1'b1, 1'b0, 0, 1000, sc, rc, f0, a0, w0, mw, wd, bh);
    err_exp = 1'b1;
    tests_run++; if (bh !== 1'b0 || sc !== TIMEOUT) begin tests_failed++; $display("[TB] FAIL timeout_stall_cycles: got %0d (bound %b) expected %0d", sc, bh, TIMEOUT); end
    tests_run++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL timeout_wb: got %b/%b/%h expected 1/0/0", wb_valid, wb_we, wb_data); end
    tests_run++; if (bus_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_err: got %b expected 1", bus_err); end
  endtask

  task automatic test_random();
    int sc, rc, wd, kind, g, l, exp_sc, exp_rc;
    logic f0, mw, bh, we, bdec, mis, aborted, exp_we;
    logic [31:0] a0, w0, res, sdata, rdata, exp_data;
    logic [RD_W-1:0] rd;
    for (int i = 0; i < 60; i++) begin
      kind  = $urandom_range(0, 3);
      res   = $urandom() & 32'hFFFF_FFFC;
      if (kind >= 2 && $urandom_range(0, 7) == 0) res = res | 32'h1;
      sdata = $urandom();
      rdata = $urandom();
      rd    = RD_W'($urandom());
      we    = 1'($urandom());
      bdec  = 1'($urandom());
      g     = $urandom_range(0, 5);
      l     = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(1, 6);
      // Reference: count cycles from issue; the access may spend at most TIMEOUT cycles past issue.
      mis      = (kind >= 2) && (res[1:0] != 2'b00);
      aborted  = 1'b0;
      exp_sc   = 0;
      exp_rc   = 0;
      exp_we   = 1'b0;
      exp_data = 32'h0;
      if (kind < 2) begin
        exp_we   = we;
        exp_data = res;
      end else if (!mis && kind == 2) begin
        if (g < TIMEOUT) begin exp_sc = g; exp_rc = g + 1; end
        else begin exp_sc = TIMEOUT; exp_rc = TIMEOUT; aborted = 1'b1; end
      end else if (!mis) begin
        if (g + l <= TIMEOUT) begin
          exp_sc = g + l; exp_rc = g + 1; exp_we = we; exp_data = rdata;
        end else begin
          exp_sc = TIMEOUT; exp_rc = (g < TIMEOUT) ? g + 1 : TIMEOUT; aborted = 1'b1;
        end
      end
      if (mis || aborted) err_exp = 1'b1;
      issue_op(kind, res, sdata, rdata, rd, we, bdec, g, l, sc, rc, f0, a0, w0, mw, wd, bh);
      tests_run++; if (bh !== 1'b0 || sc !== exp_sc) begin tests_failed++; $display("[TB] FAIL rnd%0d_stall: got %0d (bound %b) expected %0d", i, sc, bh, exp_sc); end
      tests_run++; if (rc !== exp_rc) begin tests_failed++; $display("[TB] FAIL rnd%0d_req: got %0d expected %0d", i, rc, exp_rc); end
      tests_run++; if (wd !== 0 || wb_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rnd%0d_wb_valid: got during %0d final %b expected 0/1", i, wd, wb_valid); end
      tests_run++; if (wb_we !== exp_we) begin tests_failed++; $display("[TB] FAIL rnd%0d_wb_we: got %b expected %b", i, wb_we, exp_we); end
      if (!(kind == 2 && !mis && !aborted)) begin
        tests_run++; if (wb_data !== exp_data) begin tests_failed++; $display("[TB] FAIL rnd%0d_wb_data: got %h expected %h", i, wb_data, exp_data); end
      end
      tests_run++; if (wb_rd !== rd) begin tests_failed++; $display("[TB] FAIL rnd%0d_wb_rd: got %0d expected %0d", i, wb_rd, rd); end
      tests_run++; if (f0 !== (kind == 1 && bdec)) begin tests_failed++; $display("[TB] FAIL rnd%0d_flush: got %b expected %b", i, f0, (kind == 1 && bdec)); end
      tests_run++; if (a0 !== res || w0 !== sdata || mw !== (kind == 2)) begin tests_failed++; $display("[TB] FAIL rnd%0d_bus: got %h/%h/%b expected %h/%h/%b", i, a0, w0, mw, res, sdata, (kind == 2)); end
      tests_run++; if (bus_err !== err_exp) begin tests_failed++; $display("[TB] FAIL rnd%0d_bus_err: got %b expected %b", i, bus_err, err_exp); end
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    in_valid = 1'b1; wb_sel = 1'b1; result = 32'h800; rd_in = 5'd8; reg_we_in = 1'b1; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_mid_in_wait: got stall %b expected 1", stall); end
    rst_n = 1'b0;
    #1;
    err_exp = 1'b0;
    tests_run++; if ({mem_req, stall, wb_valid} !== 3'b000) begin tests_failed++; $display("[TB] FAIL rst_mid_outputs: got %b expected 000", {mem_req, stall, wb_valid}); end
    tests_run++; if (bus_err !== err_exp) begin tests_failed++; $display("[TB] FAIL rst_mid_bus_err: got %b expected %b", bus_err, err_exp); end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests_run++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_late_rvalid%0d: got wb_valid %b stall %b expected 0/0", k, wb_valid, stall); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load_waits();
    test_branch_flush();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_random();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
